// File: rtl/mult_div_unit_if.sv
// Issue/readback bundle between the E-stage controller and the HI/LO multiply/divide unit.
// The controller drives the request side; the unit returns busy and the committed HI/LO.
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rd_hi;
   logic        busy;
   logic [31:0] rdata;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, rd_hi,
      input  busy, rdata, hi, lo
   );

   modport slave (
      input  start, op, a, b, rd_hi,
      output busy, rdata, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// HI/LO owner executing MULT/MULTU in MUL_CYCLES and DIV/DIVU in DIV_CYCLES; MTHI/MTLO take one edge.
// No backpressure is applied to requests: start while busy is silently dropped, so the controller stalls on busy.
module mult_div_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);
   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic          r_signed;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic [63:0]   w_prod;
   logic          w_a_neg;
   logic          w_b_neg;
   logic          w_div_zero;
   logic [31:0]   w_a_mag;
   logic [31:0]   w_b_mag;
   logic [31:0]   w_b_safe;
   logic [31:0]   w_q_mag;
   logic [31:0]   w_r_mag;
   logic [31:0]   w_quot;
   logic [31:0]   w_rem;

   // Low 64 bits of the product of sign-extended operands give the exact signed product.
   assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
   assign w_prod   = r_signed ? w_prod_s : w_prod_u;

   // Signed divide via magnitudes: 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
   assign w_a_neg    = r_signed & r_a[31];
   assign w_b_neg    = r_signed & r_b[31];
   assign w_div_zero = (r_b == 32'd0);
   assign w_a_mag    = w_a_neg ? (32'd0 - r_a) : r_a;
   assign w_b_mag    = w_b_neg ? (32'd0 - r_b) : r_b;
   assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
   assign w_q_mag    = w_a_mag / w_b_safe;
   assign w_r_mag    = w_a_mag % w_b_safe;
   assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_signed <= 1'b0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     3'd0, 3'd1: begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_signed <= (bus.op == 3'd0);
                        r_cnt    <= CW'(MUL_CYCLES);
                        r_busy   <= 1'b1;
                        r_state  <= ST_MUL;
                     end
                     3'd2, 3'd3: begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_signed <= (bus.op == 3'd2);
                        r_cnt    <= CW'(DIV_CYCLES);
                        r_busy   <= 1'b1;
                        r_state  <= ST_DIV;
                     end
                     3'd4:    r_hi <= bus.a;
                     3'd5:    r_lo <= bus.a;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_hi    <= w_prod[63:32];
                  r_lo    <= w_prod[31:0];
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_DIV: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  if (!w_div_zero) begin
                     r_hi <= w_rem;
                     r_lo <= w_quot;
                  end
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = r_busy;
   assign bus.hi    = r_hi;
   assign bus.lo    = r_lo;
   assign bus.rdata = bus.rd_hi ? r_hi : r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results and busy cycle counts.
module tb_mult_div_unit;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   cyc;

   mult_div_unit_if bus ();

   mult_div_unit #(
      .MUL_CYCLES (5),
      .DIV_CYCLES (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Leaves the bench 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo);
      chk({tag, "_hi"}, 64'(bus.hi), 64'(e_hi));
      chk({tag, "_lo"}, 64'(bus.lo), 64'(e_lo));
      bus.rd_hi = 1'b1;
      #1;
      chk({tag, "_rdata_hi"}, 64'(bus.rdata), 64'(e_hi));
      bus.rd_hi = 1'b0;
      #1;
      chk({tag, "_rdata_lo"}, 64'(bus.rdata), 64'(e_lo));
   endtask

   // Issues one op, then counts the cycles busy stays high after the issue edge.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n_busy);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      bus.a     = 32'hA5A5_A5A5;
      bus.b     = 32'h5A5A_5A5A;
      n_busy    = 0;
      while (bus.busy === 1'b1 && n_busy < 100) begin
         n_busy++;
         tick();
      end
   endtask

   task automatic op_case(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int e_cyc,
                          input logic [31:0] e_hi, input logic [31:0] e_lo);
      int n;
      run_op(op, a, b, n);
      chk({tag, "_busy_cycles"}, 64'(n), 64'(e_cyc));
      chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
      check_regs(tag, e_hi, e_lo);
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      bus.rd_hi = 1'b0;
      tick();
      tick();
      chk("reset_busy", 64'(bus.busy), 64'd0);
      check_regs("reset", 32'd0, 32'd0);
      reset = 1'b1;
      tick();

      op_case("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7,         5,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
      op_case("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
      op_case("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      // Issued straight after the previous commit: zero dead cycles.
      op_case("divu_b2b",  3'd3, 32'd100,       32'd7,         10, 32'd2,         32'd14);
      op_case("div_negb",  3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
      op_case("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
      op_case("divu_big",  3'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'd1,         32'h7FFF_FFFC);

      // MTHI then MTLO on consecutive cycles.
      bus.start = 1'b1;
      bus.op    = 3'd4;
      bus.a     = 32'h1234;
      tick();
      chk("mthi_busy", 64'(bus.busy), 64'd0);
      chk("mthi_hi", 64'(bus.hi), 64'h1234);
      bus.op = 3'd5;
      bus.a  = 32'h5678;
      tick();
      bus.start = 1'b0;
      chk("mtlo_busy", 64'(bus.busy), 64'd0);
      check_regs("mtlo", 32'h1234, 32'h5678);

      op_case("div_zero",  3'd2, 32'd55,        32'd0,         10, 32'h1234,      32'h5678);
      op_case("divu_zero", 3'd3, 32'd55,        32'd0,         10, 32'h1234,      32'h5678);
      op_case("nop_op6",   3'd6, 32'hDEAD,      32'hBEEF,      0,  32'h1234,      32'h5678);

      // MTLO pulsed while a MULT is in flight must be dropped.
      bus.start = 1'b1;
      bus.op    = 3'd0;
      bus.a     = 32'h0001_0000;
      bus.b     = 32'h0001_0000;
      tick();
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 100) begin
         bus.start = (cyc == 1);
         bus.op    = 3'd5;
         bus.a     = 32'hDEAD;
         bus.b     = 32'hBEEF;
         cyc++;
         tick();
      end
      bus.start = 1'b0;
      chk("mult_ignore_busy_cycles", 64'(cyc), 64'd5);
      check_regs("mult_ignore", 32'd1, 32'd0);

      // Reset in the middle of a divide aborts it with no later commit.
      bus.start = 1'b1;
      bus.op    = 3'd3;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_busy_before", 64'(bus.busy), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy_now", 64'(bus.busy), 64'd0);
      chk("abort_hi_now", 64'(bus.hi), 64'd0);
      chk("abort_lo_now", 64'(bus.lo), 64'd0);
      tick();
      reset = 1'b1;
      repeat (15) tick();
      chk("abort_busy_after", 64'(bus.busy), 64'd0);
      check_regs("abort_after", 32'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide responder for the five-stage pipeline's execute stage. It owns the HI/LO register pair and executes MULT/MULTU/DIV/DIVU over several cycles. The E-stage controller issues each operation with a one-cycle `start` pulse and stalls on `busy`. MTHI/MTLO writes and MFHI/MFLO reads complete without stalling.

## Interface
Parameters:
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (≥1).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle operation request, sampled on the rising edge.
- `op` input 3: operation code, sampled with `start`. 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
- `a` input 32: operand rs, sampled with `start`.
- `b` input 32: operand rt, sampled with `start`.
- `rd_hi` input 1: read-port select; 1 selects HI, 0 selects LO.
- `busy` output 1: high while a multiply or divide is in flight.
- `rdata` output 32: combinational copy of the selected committed HI or LO.
- `hi` output 32: committed HI register.
- `lo` output 32: committed LO register.

## Operation
- States are IDLE, MUL and DIV. `busy` = (state != IDLE). A down-counter `cnt` is wide enough for `max(MUL_CYCLES, DIV_CYCLES)`.
- In IDLE with `start`=1:
  - op 0/1: latch `a` and `b`, load `cnt`=`MUL_CYCLES`, go to MUL.
  - op 2/3: latch `a` and `b`, load `cnt`=`DIV_CYCLES`, go to DIV.
  - op 4: HI←`a` at this edge; stay in IDLE.
  - op 5: LO←`a` at this edge; stay in IDLE.
  - op 6/7: no effect.
- In MUL or DIV, `cnt` decrements each cycle. The edge where `cnt`=1 commits the result and returns to IDLE.
- Multiply results:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
- Divide results:
  - DIV: LO = signed quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (`b`=0, DIV or DIVU): runs the full `DIV_CYCLES`; HI and LO are left unchanged at commit.
- Only latched operands are used. Changing `a`/`b` while busy has no effect.
- `start` while `busy`=1 is ignored for every op, including MTHI/MTLO. The controller must not issue one.
- HI/LO are never partially updated: either both commit at the completion edge, or neither changes.

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE, `cnt`=0, `busy`=0, HI=0, LO=0, latched operands=0. `rdata` therefore reads 0.
- Reset asserted mid-operation aborts the operation; no commit occurs.
- MULT/DIV issued with `start` at edge E0:
  - `busy`=1 from just after E0 through the cycle before the commit edge.
  - Commit edge is E0+`MUL_CYCLES` (multiply) or E0+`DIV_CYCLES` (divide).
  - Just after the commit edge, `busy`=0 and the new HI/LO are visible.
- A new `start` is accepted in the first cycle where `busy`=0. Back-to-back operations therefore have zero dead cycles.
- MTHI/MTLO: value is visible on `hi`/`lo`/`rdata` one edge after `start`. `busy` never rises.
- `rdata`, `hi` and `lo` are pure functions of the registers. MFHI/MFLO has zero added latency.

## Test plan
- Reset, then MULT with a=0xFFFFFFFD (-3), b=7 -> `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU with a=b=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 100/7 -> LO=14, HI=2, issued in the first non-busy cycle.
- MTHI a=0x1234, then MTLO a=0x5678 on the following cycle -> HI=0x1234, LO=0x5678, `busy` stays 0. DIV by zero afterwards -> `busy` high 10 cycles, HI/LO unchanged.
- MULT in flight; pulse `start` with MTLO a=0xDEAD at cycle 2 -> request ignored, LO gets the product, `busy` timing unchanged.
- DIV in flight at cycle 4; assert `reset`=0 mid-cycle -> `busy`, HI and LO go to 0 immediately. No later commit after `reset` is released.
